// File: rtl/traffic_request_ctrl_if.sv
// Signal bundle between the light controller side and traffic_request_ctrl.
// The controller side (master) drives raw inputs and observed lights; the block (slave) returns requests and status.
interface traffic_request_ctrl_if;
  logic       ped_btn;
  logic [3:0] emg_sense;
  logic [2:0] n_lights;
  logic [2:0] s_lights;
  logic [2:0] e_lights;
  logic [2:0] w_lights;
  logic       ped_request;
  logic [3:0] emergency_dir;
  logic       emg_active;
  logic       ped_overdue;
  logic       light_fault;
  logic [1:0] emg_state;

  // Request semantics: ped_request and emergency_dir are level requests that stay
  // asserted until closed-loop service evidence is seen on the light inputs.
  modport master (
    output ped_btn, emg_sense, n_lights, s_lights, e_lights, w_lights,
    input  ped_request, emergency_dir, emg_active, ped_overdue, light_fault, emg_state
  );

  modport slave (
    input  ped_btn, emg_sense, n_lights, s_lights, e_lights, w_lights,
    output ped_request, emergency_dir, emg_active, ped_overdue, light_fault, emg_state
  );
endinterface

// File: rtl/traffic_request_ctrl.sv
// Request front-end for the 4-way light controller: sync/debounce, held requests, emergency FSM.
// Optional light-conflict checker enabled by defining LIGHT_CHECK_EN.
module traffic_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PED_WAIT_MAX    = 64,
  parameter int EMG_SERVICE_MAX = 32,
  parameter int EMG_COOLDOWN    = 16
) (
  input logic                    clk,
  input logic                    rst_a,
  traffic_request_ctrl_if.slave  bus
);

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b100;

  localparam int DBW  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PWW  = $clog2(PED_WAIT_MAX + 1);
  localparam int TMAX = (EMG_SERVICE_MAX > EMG_COOLDOWN) ? EMG_SERVICE_MAX : EMG_COOLDOWN;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWW-1:0] PED_LAST = PWW'(PED_WAIT_MAX);
  localparam logic [TW-1:0]  SVC_LAST = TW'(EMG_SERVICE_MAX - 1);
  localparam logic [TW-1:0]  CD_LAST  = TW'(EMG_COOLDOWN - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERT   = 2'd1,
    S_SERVICE  = 2'd2,
    S_COOLDOWN = 2'd3
  } emg_state_t;

  // Bit 4 is the pedestrian button, bits 3:0 the emergency sensors [W,E,S,N].
  logic [4:0] raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] deb;

  assign raw = {bus.ped_btn, bus.emg_sense};

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_deb
    logic           deb_q;
    logic [DBW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
        deb_q <= 1'b0;
        cnt_q <= '0;
      end else if (sync2[i] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        deb_q <= sync2[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign deb[i] = deb_q;
  end

  logic [3:0] emg_deb;
  logic       ped_deb;
  logic       all_red;

  assign emg_deb = deb[3:0];
  assign ped_deb = deb[4];
  assign all_red = (bus.n_lights == RED) && (bus.s_lights == RED) &&
                   (bus.e_lights == RED) && (bus.w_lights == RED);

  // Pedestrian request: set on debounced rising edge, cleared by an all-red phase.
  logic           ped_deb_d;
  logic           ped_pending;
  logic [PWW-1:0] ped_wait;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      ped_deb_d   <= 1'b0;
      ped_pending <= 1'b0;
      ped_wait    <= '0;
    end else begin
      ped_deb_d <= ped_deb;
      if (ped_pending && all_red) begin
        ped_pending <= 1'b0;
        ped_wait    <= '0;
      end else if (ped_pending) begin
        if (ped_wait != PED_LAST) ped_wait <= ped_wait + 1'b1;
      end else if (ped_deb && !ped_deb_d) begin
        ped_pending <= 1'b1;
      end
    end
  end

  assign bus.ped_request = ped_pending;
  assign bus.ped_overdue = (ped_wait == PED_LAST);

  emg_state_t state_q;
  emg_state_t state_d;
  logic [1:0] sel_q;
  logic [1:0] sel_d;
  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;
  logic [1:0] low_idx;
  logic [2:0] sel_light;

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (emg_deb[i]) low_idx = 2'(i);
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    sel_light = bus.n_lights;
      2'd1:    sel_light = bus.s_lights;
      2'd2:    sel_light = bus.e_lights;
      default: sel_light = bus.w_lights;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tmr_q   <= tmr_d;
    end
  end

  // The latched index only moves in IDLE, so no sensor can pre-empt an active request.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (|emg_deb) begin
          sel_d   = low_idx;
          state_d = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (!emg_deb[sel_q]) begin
          state_d = S_IDLE;
        end else if (sel_light == GREEN) begin
          state_d = S_SERVICE;
          tmr_d   = '0;
        end
      end
      S_SERVICE: begin
        if (!emg_deb[sel_q] || (tmr_q == SVC_LAST)) begin
          state_d = S_COOLDOWN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        if (tmr_q == CD_LAST) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
    endcase
  end

  logic [3:0] dir;
  logic       active;

  always_comb begin
    dir    = 4'b0000;
    active = 1'b0;
    if ((state_q == S_ASSERT) || (state_q == S_SERVICE)) begin
      dir    = 4'b0001 << sel_q;
      active = 1'b1;
    end
  end

  assign bus.emergency_dir = dir;
  assign bus.emg_active    = active;
  assign bus.emg_state     = state_q;

`ifdef LIGHT_CHECK_EN
  function automatic logic bad_code(input logic [2:0] l);
    return (l != RED) && (l != YELLOW) && (l != GREEN);
  endfunction

  logic [3:0] non_red;
  logic       fault_now;
  logic       fault_q;

  assign non_red   = {bus.w_lights != RED, bus.e_lights != RED,
                      bus.s_lights != RED, bus.n_lights != RED};
  assign fault_now = bad_code(bus.n_lights) || bad_code(bus.s_lights) ||
                     bad_code(bus.e_lights) || bad_code(bus.w_lights) ||
                     ((non_red & (non_red - 4'd1)) != 4'd0);

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) fault_q <= 1'b0;
    else if (fault_now) fault_q <= 1'b1;
  end

  assign bus.light_fault = fault_q;
`else
  assign bus.light_fault = 1'b0;
`endif

endmodule
